// File: rtl/divider_arbiter_q4_4.sv
`default_nettype none
// ============================================================================
// Module      : divider_arbiter_q4_4
// Description : Round-robin arbiter/sequencer sharing one Q4.4 signed
//               Goldschmidt divider among NUM_REQ requesters. One division
//               is in flight at a time; results come back tagged with the
//               index of the requester that was granted.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : NUM_REQ (2..8), TIMEOUT_CYCLES (WAIT watchdog limit)
// Macro       : DIV_ARB_TIMEOUT_EN - enables the WAIT-state watchdog
// Ports       : clk, rst (sync, active high)
//               req/req_numerator/req_denominator - requester side
//               gnt, rsp_valid, rsp_id, rsp_quotient, rsp_error,
//               rsp_timeout, busy                  - requester side outputs
//               div_start/div_numerator/div_denominator - to divider
//               div_quotient/div_valid/div_error        - from divider
// ============================================================================
module divider_arbiter_q4_4 #(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 63,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_numerator,
    input  logic [8*NUM_REQ-1:0] req_denominator,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_quotient,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 div_start,
    output logic [7:0]           div_numerator,
    output logic [7:0]           div_denominator,
    input  logic [7:0]           div_quotient,
    input  logic                 div_valid,
    input  logic                 div_error
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    // After reset the search starts at last_id+1, so requester 0 leads.
    localparam logic [ID_W-1:0] c_LAST_ID_RST = ID_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("divider_arbiter_q4_4: parameter out of range");
    end

    // Per-requester operand views
    logic [7:0] w_num_arr [NUM_REQ];
    logic [7:0] w_den_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_num_arr[gi] = req_numerator[8*gi +: 8];
        assign w_den_arr[gi] = req_denominator[8*gi +: 8];
    end

    state_t              r_state_q,     w_state_d;
    logic [ID_W-1:0]     r_last_id_q,   w_last_id_d;
    logic [ID_W-1:0]     r_cur_id_q,    w_cur_id_d;
    logic [7:0]          r_div_num_q,   w_div_num_d;
    logic [7:0]          r_div_den_q,   w_div_den_d;
    logic [NUM_REQ-1:0]  r_gnt_q,       w_gnt_d;
    logic                r_div_start_q, w_div_start_d;
    logic                r_rsp_valid_q, w_rsp_valid_d;
    logic [ID_W-1:0]     r_rsp_id_q,    w_rsp_id_d;
    logic [7:0]          r_rsp_quot_q,  w_rsp_quot_d;
    logic                r_rsp_err_q,   w_rsp_err_d;
    logic                r_busy_q,      w_busy_d;
`ifdef DIV_ARB_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMR_W-1:0]  r_tmr_q,       w_tmr_d;
    logic                r_rsp_to_q,    w_rsp_to_d;
`endif

    // Round-robin winner: scan offsets from the far end back towards
    // last_id+1 so the nearest pending requester overwrites the rest.
    logic [ID_W-1:0] w_win_id;

    always_comb begin
        int idx;
        idx      = 0;
        w_win_id = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(r_last_id_q) + off) % NUM_REQ;
            if (req[idx[ID_W-1:0]]) begin
                w_win_id = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_last_id_d   = r_last_id_q;
        w_cur_id_d    = r_cur_id_q;
        w_div_num_d   = r_div_num_q;
        w_div_den_d   = r_div_den_q;
        w_gnt_d       = '0;
        w_div_start_d = 1'b0;
        w_rsp_valid_d = 1'b0;
        w_rsp_id_d    = r_rsp_id_q;
        w_rsp_quot_d  = r_rsp_quot_q;
        w_rsp_err_d   = r_rsp_err_q;
`ifdef DIV_ARB_TIMEOUT_EN
        w_tmr_d       = r_tmr_q;
        w_rsp_to_d    = r_rsp_to_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (|req) begin
                    w_state_d     = ST_ISSUE;
                    w_cur_id_d    = w_win_id;
                    w_last_id_d   = w_win_id;
                    w_div_num_d   = w_num_arr[w_win_id];
                    w_div_den_d   = w_den_arr[w_win_id];
                    // gnt and start are registered so they land in ISSUE
                    w_gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_id;
                    w_div_start_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_state_d = ST_WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
                w_tmr_d   = '0;
`endif
            end
            ST_WAIT: begin
                // A real divider answer has priority over watchdog expiry
                if (div_valid) begin
                    w_state_d     = ST_RESPOND;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_id_d    = r_cur_id_q;
                    w_rsp_quot_d  = div_quotient;
                    w_rsp_err_d   = div_error;
`ifdef DIV_ARB_TIMEOUT_EN
                    w_rsp_to_d    = 1'b0;
                end else if (r_tmr_q == c_TMR_W'(TIMEOUT_CYCLES)) begin
                    w_state_d     = ST_RESPOND;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_id_d    = r_cur_id_q;
                    w_rsp_quot_d  = 8'h00;
                    w_rsp_err_d   = 1'b1;
                    w_rsp_to_d    = 1'b1;
                end else begin
                    w_tmr_d       = r_tmr_q + 1'b1;
`endif
                end
            end
            ST_RESPOND: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_last_id_q   <= c_LAST_ID_RST;
            r_cur_id_q    <= '0;
            r_div_num_q   <= '0;
            r_div_den_q   <= '0;
            r_gnt_q       <= '0;
            r_div_start_q <= 1'b0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_id_q    <= '0;
            r_rsp_quot_q  <= '0;
            r_rsp_err_q   <= 1'b0;
            r_busy_q      <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            r_tmr_q       <= '0;
            r_rsp_to_q    <= 1'b0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_last_id_q   <= w_last_id_d;
            r_cur_id_q    <= w_cur_id_d;
            r_div_num_q   <= w_div_num_d;
            r_div_den_q   <= w_div_den_d;
            r_gnt_q       <= w_gnt_d;
            r_div_start_q <= w_div_start_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_id_q    <= w_rsp_id_d;
            r_rsp_quot_q  <= w_rsp_quot_d;
            r_rsp_err_q   <= w_rsp_err_d;
            r_busy_q      <= w_busy_d;
`ifdef DIV_ARB_TIMEOUT_EN
            r_tmr_q       <= w_tmr_d;
            r_rsp_to_q    <= w_rsp_to_d;
`endif
        end
    end

    assign gnt             = r_gnt_q;
    assign div_start       = r_div_start_q;
    assign div_numerator   = r_div_num_q;
    assign div_denominator = r_div_den_q;
    assign rsp_valid       = r_rsp_valid_q;
    assign rsp_id          = r_rsp_id_q;
    assign rsp_quotient    = r_rsp_quot_q;
    assign rsp_error       = r_rsp_err_q;
    assign busy            = r_busy_q;
`ifdef DIV_ARB_TIMEOUT_EN
    assign rsp_timeout     = r_rsp_to_q;
`else
    assign rsp_timeout     = 1'b0;
`endif

endmodule
`default_nettype wire
